// File: rtl/async_rd_fwft_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_rd_fwft_stage_pkg
// Description : Shared constants and pointer helper for the read-side
//               first-word-fall-through output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package async_rd_fwft_stage_pkg;

  // Output buffer depth.
  localparam int unsigned c_BUF_DEPTH = 3;

  // Last valid pointer value; pointers wrap from here back to zero.
  localparam logic [1:0] c_PTR_LAST = 2'(c_BUF_DEPTH - 1);

  // Advance a circular buffer pointer, wrapping 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == c_PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/async_rd_fwft_stage_fwft_buf3.sv
`default_nettype none
// ============================================================================
// Module      : fwft_buf3
// Description : 3-entry circular store with write/read pointers and an
//               occupancy count. Read data is the entry at the read pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module fwft_buf3
  import async_rd_fwft_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_cnt
);

  logic [DATA_WIDTH-1:0] r_mem [0:c_BUF_DEPTH-1];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Storage array: entries are cleared on reset so the output reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(c_BUF_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and count; simultaneous write and read keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (i_rd_en) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_cnt <= r_cnt + {1'b0, i_wr_en} - {1'b0, i_rd_en};
    end
  end

  // Head-of-queue select; pointer value 3 never occurs.
  always_comb begin
    w_rd_data = r_mem[0];
    case (r_rd_ptr)
      2'd1:    w_rd_data = r_mem[1];
      2'd2:    w_rd_data = r_mem[2];
      default: w_rd_data = r_mem[0];
    endcase
  end

  assign o_rd_data = w_rd_data;
  assign o_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: rtl/async_rd_fwft_stage.sv
`default_nettype none
// ============================================================================
// Module      : async_rd_fwft_stage
// Description : Read-side output stage of the async FIFO. Issues pops against
//               a credit that covers the buffered and in-flight words, captures
//               the RAM word one cycle after each pop and presents it as a
//               first-word-fall-through valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module async_rd_fwft_stage
  import async_rd_fwft_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_cnt
);

  localparam logic [1:0] c_DEPTH = 2'(c_BUF_DEPTH);

  logic       r_inflight;
  logic [1:0] w_buf_cnt;
  logic [1:0] w_credit;
  logic       w_rd_en;
  logic       w_pop;
  logic       w_m_valid;
  logic       w_hs;

  // Credit counts free slots not already claimed by the word in flight;
  // built from registers only so m_ready never reaches fifo_rd_en.
  assign w_credit  = c_DEPTH - w_buf_cnt - {1'b0, r_inflight};
  assign w_rd_en   = (w_credit != 2'd0) & ~rd_rst;
  assign w_pop     = w_rd_en & ~fifo_empty;
  assign w_m_valid = (w_buf_cnt != 2'd0);
  assign w_hs      = w_m_valid & m_ready;

  // Marks that ram_rd_data carries a freshly popped word this cycle.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
    end
  end

  fwft_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .i_wr_en   (r_inflight),
    .i_wr_data (ram_rd_data),
    .i_rd_en   (w_hs),
    .o_rd_data (m_data),
    .o_cnt     (w_buf_cnt)
  );

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = w_m_valid;
  assign buf_cnt    = w_buf_cnt;

endmodule
`default_nettype wire
